// File: rtl/scanner_ctrl_param.sv
// Scanner phase sequencer with occupancy counter; SCANNER_IDLE_TIMEOUT_EN adds IDLE auto-flush.
// Latency: state/data_count registered (1 clk); flags are zero-latency decodes of those registers.
// Backpressure: none; requests are sampled every cycle and acted on in priority order.
module scanner_ctrl_param #(
    parameter int CNT_W        = 8,
    parameter int DEPTH        = 100,
    parameter int READY_THRESH = 80,
    parameter int START_THRESH = 90,
    parameter int FILL_STEP    = 1,
    parameter int DRAIN_STEP   = 1,
    parameter int FLUSH_STEP   = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_scan,
    input  logic             transfer,
    input  logic             flush_signal,
    input  logic             go_to_standby,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] data_count,
    output logic             ready_to_transfer,
    output logic             ready_second_buffer,
    output logic             start_second_buffer,
    output logic             buffer_full,
    output logic             buffer_empty
`ifdef SCANNER_IDLE_TIMEOUT_EN
    ,
    output logic             timeout_flush
`endif
);

    typedef enum logic [2:0] {
        S_LOW_POWER = 3'd0,
        S_ACTIVE    = 3'd1,
        S_STANDBY   = 3'd2,
        S_IDLE      = 3'd3,
        S_FLUSH     = 3'd4,
        S_TRANSFER  = 3'd5
    } state_t;

    localparam logic [CNT_W:0]   DEPTH_X = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W:0]   FILL_X  = (CNT_W+1)'(FILL_STEP);
    localparam logic [CNT_W:0]   DRAIN_X = (CNT_W+1)'(DRAIN_STEP);
    localparam logic [CNT_W:0]   FLUSH_X = (CNT_W+1)'(FLUSH_STEP);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] READY_C = CNT_W'(READY_THRESH);
    localparam logic [CNT_W-1:0] START_C = CNT_W'(START_THRESH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_x, fill_sum, drain_dif, flush_dif;

    // One extra bit of headroom so the clamps see overflow/underflow instead of a wrap.
    assign cnt_x     = {1'b0, cnt_q};
    assign fill_sum  = cnt_x + FILL_X;
    assign drain_dif = cnt_x - DRAIN_X;
    assign flush_dif = cnt_x - FLUSH_X;

`ifdef SCANNER_IDLE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              idle_quiet, timeout_hit;

    assign idle_quiet    = (state_q == S_IDLE) && !transfer && !flush_signal;
    assign timeout_hit   = idle_quiet && (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1));
    assign timeout_flush = timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            idle_cnt_q <= '0;
        else if (idle_quiet && !timeout_hit)
            idle_cnt_q <= idle_cnt_q + 1'b1;
        else
            idle_cnt_q <= '0;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW_POWER: begin
                if (start_scan && !transfer) state_d = S_ACTIVE;
                else if (go_to_standby)      state_d = S_STANDBY;
            end
            S_STANDBY: begin
                if (start_scan) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (transfer)               state_d = S_TRANSFER;
                else if (cnt_q == DEPTH_C)  state_d = S_IDLE;
                else cnt_d = (fill_sum > DEPTH_X) ? DEPTH_C : fill_sum[CNT_W-1:0];
            end
            S_IDLE: begin
                if (transfer)          state_d = S_TRANSFER;
                else if (flush_signal) state_d = S_FLUSH;
`ifdef SCANNER_IDLE_TIMEOUT_EN
                else if (timeout_hit)  state_d = S_FLUSH;
`endif
            end
            S_FLUSH: begin
                if (cnt_q == '0) state_d = S_LOW_POWER;
                cnt_d = (cnt_x < FLUSH_X) ? '0 : flush_dif[CNT_W-1:0];
            end
            S_TRANSFER: begin
                if (cnt_q == '0) state_d = S_LOW_POWER;
                cnt_d = (cnt_x < DRAIN_X) ? '0 : drain_dif[CNT_W-1:0];
            end
            default: state_d = S_LOW_POWER;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOW_POWER;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state               = state_q;
    assign data_count          = cnt_q;
    assign ready_second_buffer = (state_q == S_ACTIVE) && (cnt_q >= READY_C);
    assign start_second_buffer = (state_q == S_ACTIVE) && (cnt_q >= START_C);
    assign ready_to_transfer   = ready_second_buffer || (state_q == S_IDLE) ||
                                 ((state_q == S_TRANSFER) && (cnt_q != '0));
    assign buffer_full         = (cnt_q == DEPTH_C);
    assign buffer_empty        = (cnt_q == '0);

endmodule
